// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the 5-stage MIPS hazard/stall controller.
//   state_t   : controller FSM encoding (RUN / MEM_WAIT / TIMEOUT)
//   REG_ZERO  : architectural $zero, never a real dependency
//   NOP_INSTR : all-zero instruction loaded into IF/ID when it is flushed
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'b0;

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use comparator.
// Ports:
//   i_mem_read  : instruction in EX is a load
//   i_idex_rt   : load destination register
//   i_ifid_rs   : rs of the instruction in ID
//   i_ifid_rt   : rt of the instruction in ID
//   o_load_use  : ID instruction consumes the load result too early
// -----------------------------------------------------------------------------
module hazard_detect
  import hazard_pkg::*;
(
  input  logic       i_mem_read,
  input  logic [4:0] i_idex_rt,
  input  logic [4:0] i_ifid_rs,
  input  logic [4:0] i_ifid_rt,
  output logic       o_load_use
);

  // A load into $zero writes nothing, so it can never create a dependency.
  assign o_load_use = i_mem_read && (i_idex_rt != REG_ZERO) &&
                      ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard and stall controller for the 5-stage MIPS core. Produces
// PC hold, IF/ID hold/flush and ID/EX bubble controls from load-use hazards,
// control transfers resolved in ID and multi-cycle data-memory accesses. A
// small FSM freezes the pipeline while MEM waits for acknowledge, with a
// timeout guard that raises a sticky error flag.
//
// Optional feature macro: HAZARD_PERF_EN (adds saturating perf counters).
//
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   IDEX_MemRead_i      : EX instruction is a load
//   IDEX_RegRt_i        : load destination register
//   IFID_RegRs_i/Rt_i   : source registers of the ID instruction
//   branch_taken_i      : branch in ID resolved taken
//   jump_i              : jump in ID
//   mem_req_i/mem_ack_i : data-memory request / completion
//   PCWrite_o           : 1 = hold PC
//   IFIDWrite_o         : 1 = hold IF/ID
//   flush_o             : 1 = IF/ID loads NOP_INSTR
//   bubble_o            : 1 = zero ID/EX control fields
//   freeze_o            : 1 = hold all pipeline registers (MEM wait)
//   err_o               : sticky memory-timeout flag
//   stall_cnt_o, flush_cnt_o, freeze_cnt_o : perf counters (HAZARD_PERF_EN)
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RegRt_i,
  input  logic [4:0]       IFID_RegRs_i,
  input  logic [4:0]       IFID_RegRt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             flush_o,
  output logic             bubble_o,
  output logic             freeze_o,
  output logic             err_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o
`endif
);

  localparam int              WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TMO  = WCNT_W'(MEM_TIMEOUT);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
    $error("hazard_ctrl: MEM_TIMEOUT must be 1..255 and CNT_W >= 1");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [WCNT_W-1:0] w_wait_nxt;
  logic              r_err;
  logic              w_set_err;
  logic              w_load_use;
  logic              w_ctl_xfer;
  logic              w_freeze;
  logic              w_stall;

  hazard_detect u_detect (
    .i_mem_read (IDEX_MemRead_i),
    .i_idex_rt  (IDEX_RegRt_i),
    .i_ifid_rs  (IFID_RegRs_i),
    .i_ifid_rt  (IFID_RegRt_i),
    .o_load_use (w_load_use)
  );

  assign w_ctl_xfer = branch_taken_i || jump_i;

  // In MEM_WAIT the freeze lasts until ack; elsewhere a request that is not
  // acknowledged in the same cycle starts a new wait.
  assign w_freeze = (r_state == MEM_WAIT) ? !mem_ack_i : (mem_req_i && !mem_ack_i);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_set_err) r_err <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_set_err   = 1'b0;
    case (r_state)
      MEM_WAIT: begin
        if (mem_ack_i) begin
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end else if (r_wait_cnt == TMO) begin
          w_state_nxt = TIMEOUT;
          w_wait_nxt  = '0;
          w_set_err   = 1'b1;
        end else begin
          w_wait_nxt  = r_wait_cnt + WCNT_W'(1);
        end
      end
      RUN, TIMEOUT: begin
        if (mem_req_i && !mem_ack_i) begin
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = WCNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // Output logic: reset > freeze > load-use > control transfer
  always_comb begin
    PCWrite_o   = 1'b0;
    IFIDWrite_o = 1'b0;
    flush_o     = 1'b0;
    bubble_o    = 1'b0;
    freeze_o    = 1'b0;
    w_stall     = 1'b0;
    if (rst_i) begin
      flush_o  = 1'b1;
      bubble_o = 1'b1;
    end else if (w_freeze) begin
      PCWrite_o   = 1'b1;
      IFIDWrite_o = 1'b1;
      freeze_o    = 1'b1;
    end else if (w_load_use) begin
      // The branch/jump in ID is dropped here and re-resolved next cycle.
      PCWrite_o   = 1'b1;
      IFIDWrite_o = 1'b1;
      bubble_o    = 1'b1;
      w_stall     = 1'b1;
    end else if (w_ctl_xfer) begin
      flush_o = 1'b1;
    end
  end

  assign err_o = r_err && !rst_i;

`ifdef HAZARD_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_freeze_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else begin
      r_stall_cnt  <= sat_inc(r_stall_cnt,  w_stall);
      r_flush_cnt  <= sat_inc(r_flush_cnt,  flush_o);
      r_freeze_cnt <= sat_inc(r_freeze_cnt, freeze_o);
    end
  end

  assign stall_cnt_o  = r_stall_cnt;
  assign flush_cnt_o  = r_flush_cnt;
  assign freeze_cnt_o = r_freeze_cnt;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Generates the PC-hold, IF/ID hold, IF/ID flush and ID/EX bubble controls.
- Sources handled: load-use hazards, taken branches/jumps resolved in ID, and multi-cycle data-memory accesses.
- Holds a small FSM that freezes the pipeline while a MEM-stage access waits for acknowledge, with a timeout guard.

Parameters:
- MEM_TIMEOUT, 255: max MEM_WAIT cycles before declaring a timeout (1..255).
- CNT_W, 16: width of the performance counters (used only with the optional feature).

Ports:
- clk_i  in  1  clock; state updates on posedge (IF/ID samples controls on negedge).
- rst_i  in  1  synchronous, active-high reset.
- IDEX_MemRead_i  in  1  instruction in EX is a load.
- IDEX_RegRt_i  in  5  load destination register.
- IFID_RegRs_i  in  5  rs of instruction in ID.
- IFID_RegRt_i  in  5  rt of instruction in ID.
- branch_taken_i  in  1  branch in ID resolved taken.
- jump_i  in  1  jump in ID.
- mem_req_i  in  1  MEM stage issues a data-memory access.
- mem_ack_i  in  1  data memory completes the access this cycle.
- PCWrite_o  out  1  1 = hold PC.
- IFIDWrite_o  out  1  1 = hold IF/ID (stall); 0 = write.
- flush_o  out  1  1 = IF/ID loads zero instruction.
- bubble_o  out  1  1 = zero ID/EX control fields.
- freeze_o  out  1  1 = hold all pipeline registers (MEM wait).
- err_o  out  1  sticky memory-timeout flag.

Behaviour:
- FSM states: RUN, MEM_WAIT, TIMEOUT. Registered state; outputs are combinational from state and inputs, stable before negedge.
- Reset (rst_i=1 at posedge): state=RUN, wait_cnt=0, err_o=0. While rst_i is high: flush_o=1, bubble_o=1, all other outputs 0. Reset during MEM_WAIT or TIMEOUT aborts to RUN.
- Load-use condition: IDEX_MemRead_i && IDEX_RegRt_i!=0 && (IDEX_RegRt_i==IFID_RegRs_i || IDEX_RegRt_i==IFID_RegRt_i).
- Control-transfer condition: branch_taken_i || jump_i.
- RUN, mem_req_i=1 and mem_ack_i=0:
  - freeze_o=1, PCWrite_o=1, IFIDWrite_o=1; flush_o=0, bubble_o=0.
  - Next state MEM_WAIT, wait_cnt=1.
- RUN, mem_req_i=1 and mem_ack_i=1: zero-wait access, no freeze; evaluate the remaining rules.
- RUN, no freeze, priority load-use > control-transfer > none:
  - Load-use: PCWrite_o=1, IFIDWrite_o=1, bubble_o=1, flush_o=0. The branch is re-evaluated next cycle once its operand is available.
  - Control transfer: flush_o=1, PCWrite_o=0, IFIDWrite_o=0, bubble_o=0.
  - None: all outputs 0.
- MEM_WAIT:
  - freeze_o=PCWrite_o=IFIDWrite_o=1 while mem_ack_i=0; flush_o=bubble_o=0. Hazard inputs are ignored.
  - mem_ack_i=1: freeze released in the same cycle, hazard rules applied as in RUN, next state RUN, wait_cnt=0.
  - Otherwise wait_cnt++. If wait_cnt==MEM_TIMEOUT and no ack: next state TIMEOUT.
- TIMEOUT: err_o=1 (sticky until reset), freeze released, behaves as RUN for hazards. A new mem_req_i without ack re-enters MEM_WAIT, and err_o stays 1.
- wait_cnt width is $clog2(MEM_TIMEOUT+1); it never wraps.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs stall_cnt_o, flush_cnt_o and freeze_cnt_o, each CNT_W bits.
  - Each increments once per cycle its condition is active: load-use stall, flush_o, freeze_o.
  - Counters saturate at all-ones and clear on reset.
- Undefined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg holds:
  - state encoding (RUN=2'd0, MEM_WAIT=2'd1, TIMEOUT=2'd2);
  - REG_ZERO=5'd0;
  - the NOP instruction constant 32'b0 used by the flush path.
- Natural sub-module: hazard_detect, a purely combinational load-use comparator. FSM and counters stay in hazard_ctrl.

Test Plan:
- Load-use: lw to $8 in EX, ID uses rs=$8 -> PCWrite_o=IFIDWrite_o=bubble_o=1 for 1 cycle; next cycle (load gone from EX) all 0.
- Load to $0: IDEX_RegRt_i=0 matching rs=0 -> no stall.
- Taken branch without hazard -> flush_o=1, PCWrite_o=0, IFIDWrite_o=0 for 1 cycle. Branch plus load-use together -> stall only, flush_o=0.
- mem_req_i with ack after 3 cycles -> freeze_o=1 for 3 cycles, released in the ack cycle; state back to RUN; branch_taken_i asserted during the wait produces no flush.
- MEM_TIMEOUT=4, never ack -> TIMEOUT reached after 4 wait cycles, err_o=1 and stays 1. rst_i pulse -> err_o=0, state RUN.
- rst_i asserted mid MEM_WAIT -> freeze_o=0, flush_o=bubble_o=1 during reset; RUN after release. With HAZARD_PERF_EN, CNT_W=2 -> counters saturate at 3.
